// File: rtl/memory_responder.sv
// Req/ack responder for the basic-computer word memory with wait states and post-reset fill.
// Define MEM_PARITY_EN to store an even-parity bit per word and report read parity errors on perr.
module memory_responder #(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 16,
   parameter int WAIT_CYCLES = 1,
   parameter int INIT_FILL   = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              read,
   input  logic              write,
   input  logic [ADDR_W-1:0] adress,
   input  logic [DATA_W-1:0] indata,
   output logic [DATA_W-1:0] outdata,
   output logic              ack,
   output logic              err,
   output logic              busy,
   output logic              perr
);

`ifdef MEM_PARITY_EN
   localparam int MW = DATA_W + 1;
`else
   localparam int MW = DATA_W;
`endif
   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [2:0] S_FILL   = 3'd0;
   localparam logic [2:0] S_IDLE   = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_ACCESS = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]        state;
   logic [ADDR_W-1:0] fill_cnt;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] data_q;
   logic              rd_q;
   logic              wr_q;
   logic [3:0]        wait_cnt;
   logic              err_q;
   logic [MW-1:0]     mem [DEPTH];
   logic [MW-1:0]     rword;

   function automatic logic [MW-1:0] enc(input logic [DATA_W-1:0] d);
`ifdef MEM_PARITY_EN
      return {^d, d};
`else
      return d;
`endif
   endfunction

   assign rword = mem[addr_q];
   assign busy  = (state != S_IDLE);
   assign ack   = (state == S_DONE);
   assign err   = err_q;

`ifdef MEM_PARITY_EN
   logic perr_q;
   assign perr = perr_q;
`else
   assign perr = 1'b0;
`endif

   // DONE accepts a new request directly so a held req streams at full rate
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= (INIT_FILL != 0) ? S_FILL : S_IDLE;
         fill_cnt <= '0;
         addr_q   <= '0;
         data_q   <= '0;
         rd_q     <= 1'b0;
         wr_q     <= 1'b0;
         wait_cnt <= '0;
         outdata  <= '0;
         err_q    <= 1'b0;
`ifdef MEM_PARITY_EN
         perr_q   <= 1'b0;
`endif
      end else begin
         err_q <= 1'b0;
`ifdef MEM_PARITY_EN
         perr_q <= 1'b0;
`endif
         unique case (state)
            S_FILL: begin
               if (fill_cnt == '1) state <= S_IDLE;
               else fill_cnt <= fill_cnt + 1'b1;
            end
            S_IDLE, S_DONE: begin
               if (req) begin
                  addr_q   <= adress;
                  data_q   <= indata;
                  rd_q     <= read;
                  wr_q     <= write;
                  wait_cnt <= 4'(WAIT_CYCLES);
                  state    <= (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
               end else begin
                  state <= S_IDLE;
               end
            end
            S_WAIT: begin
               if (wait_cnt <= 4'd1) state <= S_ACCESS;
               else wait_cnt <= wait_cnt - 4'd1;
            end
            S_ACCESS: begin
               state <= S_DONE;
               err_q <= rd_q & wr_q;
               if (rd_q && !wr_q) begin
                  outdata <= rword[DATA_W-1:0];
`ifdef MEM_PARITY_EN
                  perr_q  <= ^rword;
`endif
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Array has no reset; fill and normal writes share the single write port
   always_ff @(posedge clk) begin
      if (state == S_FILL) begin
         mem[fill_cnt] <= enc(DATA_W'(fill_cnt));
      end else if (state == S_ACCESS && wr_q && !rd_q) begin
         mem[addr_q] <= enc(data_q);
      end
   end

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: three instances (wait 1 with fill, wait 0, wait 15)
// checked against per-instance array models.
module tb_memory_responder;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [2:0]  req;
   logic        rd, wr;
   logic [11:0] adr;
   logic [15:0] din;
   logic [15:0] od [3];
   logic        ak [3];
   logic        er [3];
   logic        bz [3];
   logic        pe [3];

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int waitc [3] = '{1, 0, 15};
   logic [15:0] refm [3][4096];
   logic [15:0] mout [3];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   memory_responder #(.WAIT_CYCLES(1), .INIT_FILL(1)) dut0 (
      .clk(clk), .rst_n(rst_n), .req(req[0]), .read(rd), .write(wr),
      .adress(adr), .indata(din), .outdata(od[0]), .ack(ak[0]),
      .err(er[0]), .busy(bz[0]), .perr(pe[0]));
   memory_responder #(.WAIT_CYCLES(0), .INIT_FILL(0)) dut1 (
      .clk(clk), .rst_n(rst_n), .req(req[1]), .read(rd), .write(wr),
      .adress(adr), .indata(din), .outdata(od[1]), .ack(ak[1]),
      .err(er[1]), .busy(bz[1]), .perr(pe[1]));
   memory_responder #(.WAIT_CYCLES(15), .INIT_FILL(0)) dut2 (
      .clk(clk), .rst_n(rst_n), .req(req[2]), .read(rd), .write(wr),
      .adress(adr), .indata(din), .outdata(od[2]), .ack(ak[2]),
      .err(er[2]), .busy(bz[2]), .perr(pe[2]));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic do_op(input int d, input logic r, input logic w,
                        input logic [11:0] a, input logic [15:0] v,
                        input logic exp_pe);
      int n;
      bit seen;
      @(negedge clk);
      req[d] = 1'b1; rd = r; wr = w; adr = a; din = v;
      @(posedge clk);
      @(negedge clk);
      req[d] = 1'b0;
      rd = 1'($urandom); wr = 1'($urandom);
      adr = 12'($urandom); din = 16'($urandom);
      check("ack_early", ak[d], 1'b0);
      n = 0;
      seen = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         @(posedge clk);
         n++;
         @(negedge clk);
         seen = ak[d];
      end
      check("ack_timeout", seen, 1'b1);
      check("latency", n, waitc[d] + 1);
      if (r && !w) mout[d] = refm[d][a];
      if (w && !r) refm[d][a] = v;
      check("err", er[d], r & w);
      check("outdata", od[d], mout[d]);
      check("perr", pe[d], exp_pe);
      @(posedge clk);
      @(negedge clk);
      check("ack_pulse", ak[d], 1'b0);
      check("busy_end", bz[d], 1'b0);
   endtask

   initial begin
      int bad, n, c1, c2;
      logic [11:0] a;
      logic [15:0] v;
      req = '0; rd = 0; wr = 0; adr = '0; din = '0;
      for (int d = 0; d < 3; d++) mout[d] = '0;
      for (int i = 0; i < 4096; i++) refm[0][i] = 16'(i);

      repeat (3) @(negedge clk);
      for (int d = 0; d < 3; d++) begin
         check("rst_outdata", od[d], 16'h0);
         check("rst_ack", ak[d], 1'b0);
         check("rst_err", er[d], 1'b0);
         check("rst_perr", pe[d], 1'b0);
         check("rst_busy", bz[d], (d == 0) ? 1'b1 : 1'b0);
      end

      // hold a read request through the fill: ignored, then taken at first IDLE edge
      req[0] = 1'b1; rd = 1'b1; wr = 1'b0; adr = 12'h777;
      rst_n = 1'b1;
      bad = 0;
      for (int i = 1; i <= 4096; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (i < 4096 && bz[0] !== 1'b1) bad++;
         if (ak[0] !== 1'b0) bad++;
      end
      check("fill_busy_cycles", bad, 0);
      check("fill_end_busy", bz[0], 1'b0);
      @(posedge clk);
      @(negedge clk);
      req[0] = 1'b0;
      check("held_req_busy", bz[0], 1'b1);
      @(posedge clk);
      @(negedge clk);
      check("held_req_ack_wait", ak[0], 1'b0);
      @(posedge clk);
      @(negedge clk);
      mout[0] = 16'h0777;
      check("held_req_ack", ak[0], 1'b1);
      check("held_req_data", od[0], 16'h0777);

      for (int i = 0; i < 4096; i++) do_op(0, 1'b1, 1'b0, 12'(i), 16'h0, 1'b0);

      // write then read, req held across both
      @(negedge clk);
      req[0] = 1'b1; rd = 1'b0; wr = 1'b1; adr = 12'hABC; din = 16'hBEEF;
      @(posedge clk);
      @(negedge clk);
      rd = 1'b1; wr = 1'b0; din = 16'h0;
      c1 = -1; c2 = -1;
      for (int i = 0; i < 20 && c2 < 0; i++) begin
         @(posedge clk);
         @(negedge clk);
         if (c1 >= 0 && cyc == c1 + 1) req[0] = 1'b0;
         if (ak[0] === 1'b1) begin
            if (c1 < 0) begin
               c1 = cyc;
               check("b2b_write_out", od[0], mout[0]);
            end else begin
               c2 = cyc;
            end
         end
      end
      req[0] = 1'b0;
      refm[0][12'hABC] = 16'hBEEF;
      mout[0] = 16'hBEEF;
      check("b2b_second_ack", c2 >= 0, 1'b1);
      check("b2b_spacing", c2 - c1, 3);
      check("b2b_read_data", od[0], 16'hBEEF);
      @(posedge clk);
      @(negedge clk);
      check("b2b_ack_drop", ak[0], 1'b0);

      do_op(0, 1'b1, 1'b1, 12'h010, 16'h5555, 1'b0);
      do_op(0, 1'b1, 1'b0, 12'h010, 16'h0, 1'b0);
      check("err_word_kept", od[0], 16'h0010);

      for (int k = 0; k < 6; k++) begin
         for (int d = 1; d < 3; d++) begin
            a = 12'($urandom); v = 16'($urandom);
            do_op(d, 1'b0, 1'b1, a, v, 1'b0);
            do_op(d, 1'b1, 1'b0, a, 16'h0, 1'b0);
         end
      end
      do_op(1, 1'b1, 1'b1, 12'h3, 16'h1, 1'b0);

`ifdef MEM_PARITY_EN
      dut0.mem[12'h020][16] = ~dut0.mem[12'h020][16];
      do_op(0, 1'b1, 1'b0, 12'h020, 16'h0, 1'b1);
      check("perr_data", od[0], 16'h0020);
      do_op(0, 1'b0, 1'b1, 12'h020, 16'h0020, 1'b0);
      n = 3750;
`else
      n = 200;
`endif
      for (int k = 0; k < n; k++) begin
         a = 12'($urandom); v = 16'($urandom);
         do_op(0, 1'b0, 1'b1, a, v, 1'b0);
         if ($urandom_range(1, 0) == 1) a = 12'($urandom);
         do_op(0, 1'b1, 1'b0, a, 16'h0, 1'b0);
      end

      // reset while a write sits in WAIT
      @(negedge clk);
      req[0] = 1'b1; rd = 1'b0; wr = 1'b1; adr = 12'h005; din = 16'h1234;
      @(posedge clk);
      @(negedge clk);
      req[0] = 1'b0;
      rst_n = 1'b0;
      #1;
      for (int d = 0; d < 3; d++) begin
         mout[d] = '0;
         check("midrst_outdata", od[d], 16'h0);
         check("midrst_ack", ak[d], 1'b0);
         check("midrst_err", er[d], 1'b0);
         check("midrst_perr", pe[d], 1'b0);
         check("midrst_busy", bz[d], (d == 0) ? 1'b1 : 1'b0);
      end
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      n = 0;
      while (bz[0] === 1'b1 && n < 5000) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         if (ak[0] !== 1'b0) bad++;
      end
      check("refill_cycles", n, 4096);
      check("refill_no_ack", bad, 0);
      for (int i = 0; i < 4096; i++) refm[0][i] = 16'(i);
      do_op(0, 1'b1, 1'b0, 12'h005, 16'h0, 1'b0);
      check("aborted_write", od[0], 16'h0005);
      do_op(0, 1'b1, 1'b0, 12'hABC, 16'h0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
